// File: rtl/add_pkg.sv
// rtl/add_pkg.sv - shared state encoding and sizing helper for the multiword adder
package add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Slice counter width; a single-slice configuration still needs one bit.
    function automatic int cnt_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/add_slice.sv
// rtl/add_slice.sv - N-bit combinational ripple-carry slice
//   A, B : slice operands    Cin  : carry in
//   Sum  : slice sum         Cout : carry out of bit N-1
//   Cmsb : carry into bit N-1 (used for signed overflow on the top slice)
module add_slice #(
    parameter int N = 4
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    output logic [N-1:0] Sum,
    output logic         Cout,
    output logic         Cmsb
);

    logic [N:0] c;

    always_comb begin
        c    = '0;
        c[0] = Cin;
        for (int i = 0; i < N; i++) begin
            c[i+1] = (A[i] & B[i]) | (A[i] & c[i]) | (B[i] & c[i]);
        end
        Sum  = A ^ B ^ c[N-1:0];
        Cout = c[N];
        Cmsb = c[N-1];
    end

endmodule

// File: rtl/multiword_add_ctrl.sv
// rtl/multiword_add_ctrl.sv - sequences one N-bit slice over WORDS cycles for W-bit add/sub
//   CLK, RST (sync, active high)
//   Start, Sub, A, B : operation request and operands, sampled when not Busy
//   Busy  : high while slices are processed
//   Done  : one-cycle pulse, Sum/Cout/Ovf valid
//   Sum, Cout, Ovf   : result, unsigned carry out, signed overflow
module multiword_add_ctrl
    import add_pkg::*;
#(
    parameter  int N     = 4,
    parameter  int WORDS = 4,
    localparam int W     = N * WORDS
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         Start,
    input  logic         Sub,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic         Busy,
    output logic         Done,
    output logic [W-1:0] Sum,
    output logic         Cout,
    output logic         Ovf
);

    localparam int CW = cnt_width(WORDS);

    state_t         state, state_nxt;
    logic [CW-1:0]  count;
    logic           carry;
    logic [W-1:0]   a_sh, b_sh;
    logic           accept;
    logic           last;

    logic [N-1:0]   s_sum;
    logic           s_cout, s_cmsb;

    add_slice #(.N(N)) u_slice (
        .A    (a_sh[N-1:0]),
        .B    (b_sh[N-1:0]),
        .Cin  (carry),
        .Sum  (s_sum),
        .Cout (s_cout),
        .Cmsb (s_cmsb)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = (count == CW'(WORDS - 1));
        Busy      = 1'b0;
        Done      = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                Busy = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                Done = 1'b1;
                // Back-to-back requests are taken straight from DONE.
                if (Start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            count <= '0;
            carry <= 1'b0;
            a_sh  <= '0;
            b_sh  <= '0;
            Sum   <= '0;
            Cout  <= 1'b0;
            Ovf   <= 1'b0;
        end else if (accept) begin
            // Subtraction is A + ~B + 1: invert B here and seed the carry.
            count <= '0;
            carry <= Sub;
            a_sh  <= A;
            b_sh  <= B ^ {W{Sub}};
            Sum   <= '0;
        end else if (state == RUN) begin
            Sum[count*N +: N] <= s_sum;
            carry <= s_cout;
            a_sh  <= a_sh >> N;
            b_sh  <= b_sh >> N;
            if (last) begin
                Cout <= s_cout;
                Ovf  <= s_cmsb ^ s_cout;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_multiword_add_ctrl.sv
// tb/tb_multiword_add_ctrl.sv - directed self-checking bench for multiword_add_ctrl
module tb_multiword_add_ctrl;
    import add_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        Start;
    logic        Sub;
    logic [15:0] A, B;
    logic        Busy, Done, Cout, Ovf;
    logic [15:0] Sum;

    int vectors    = 0;
    int miscompares = 0;

    multiword_add_ctrl #(.N(4), .WORDS(4)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .Start (Start),
        .Sub   (Sub),
        .A     (A),
        .B     (B),
        .Busy  (Busy),
        .Done  (Done),
        .Sum   (Sum),
        .Cout  (Cout),
        .Ovf   (Ovf)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one operation and follow it to its Done pulse.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic sub, input logic [15:0] exp_sum,
                          input logic exp_cout, input logic exp_ovf);
        int busy_n;
        int n;
        @(negedge CLK);
        Start = 1'b1; A = a; B = b; Sub = sub;
        @(negedge CLK);
        Start = 1'b0; A = 16'h0; B = 16'h0; Sub = 1'b0;
        busy_n = 0;
        n = 0;
        while (!Done && n < 20) begin
            if (Busy) busy_n++;
            @(negedge CLK);
            n++;
        end
        check({tag, " done_seen"}, 32'(Done), 32'd1);
        check({tag, " busy_cycles"}, 32'(busy_n), 32'd4);
        check({tag, " sum"}, 32'(Sum), 32'(exp_sum));
        check({tag, " cout"}, 32'(Cout), 32'(exp_cout));
        check({tag, " ovf"}, 32'(Ovf), 32'(exp_ovf));
        @(negedge CLK);
        check({tag, " done_pulse_len"}, 32'(Done), 32'd0);
        check({tag, " sum_held"}, 32'(Sum), 32'(exp_sum));
    endtask

    initial begin
        int n;
        int done_n;
        int done_at[3];
        RST = 1'b1; Start = 1'b0; Sub = 1'b0; A = 16'h0; B = 16'h0;
        repeat (3) @(negedge CLK);
        check("reset busy", 32'(Busy), 32'd0);
        check("reset done", 32'(Done), 32'd0);
        check("reset sum",  32'(Sum),  32'd0);
        check("reset cout", 32'(Cout), 32'd0);
        check("reset ovf",  32'(Ovf),  32'd0);
        RST = 1'b0;

        run_op("add_carry_chain", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
        run_op("add_wrap",        16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("add_ovf",         16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("sub_borrow",      16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op("sub_ovf",         16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // Start re-pulsed while busy must be ignored.
        @(negedge CLK);
        Start = 1'b1; A = 16'h0003; B = 16'h0004; Sub = 1'b0;
        @(negedge CLK);
        Start = 1'b1; A = 16'hFFFF; B = 16'hFFFF; Sub = 1'b1;
        check("ignore busy_now", 32'(Busy), 32'd1);
        @(negedge CLK);
        Start = 1'b0; A = 16'h0; B = 16'h0; Sub = 1'b0;
        n = 0;
        while (!Done && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check("ignore done_seen", 32'(Done), 32'd1);
        check("ignore done_latency", 32'(n), 32'd3);
        check("ignore sum", 32'(Sum), 32'h0007);
        check("ignore cout", 32'(Cout), 32'd0);
        @(negedge CLK);
        check("ignore back_to_idle", 32'(Busy), 32'd0);

        // Reset in the third RUN cycle aborts the operation.
        @(negedge CLK);
        Start = 1'b1; A = 16'h1234; B = 16'h1111; Sub = 1'b0;
        @(negedge CLK);
        Start = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        check("abort in_run", 32'(Busy), 32'd1);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("abort busy", 32'(Busy), 32'd0);
        check("abort sum",  32'(Sum),  32'd0);
        check("abort done", 32'(Done), 32'd0);
        check("abort cout", 32'(Cout), 32'd0);
        done_n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            if (Done) done_n++;
        end
        check("abort no_done", 32'(done_n), 32'd0);

        // Start held high: a result every WORDS+1 cycles.
        @(negedge CLK);
        Start = 1'b1; A = 16'h0001; B = 16'h0001; Sub = 1'b0;
        done_n = 0;
        for (int i = 0; i < 20 && done_n < 3; i++) begin
            @(negedge CLK);
            if (Done) begin
                done_at[done_n] = i;
                done_n++;
                check("stream sum", 32'(Sum), 32'h0002);
            end
        end
        Start = 1'b0;
        check("stream done_count", 32'(done_n), 32'd3);
        if (done_n == 3) begin
            check("stream first_latency", 32'(done_at[0]), 32'd4);
            check("stream period_1", 32'(done_at[1] - done_at[0]), 32'd5);
            check("stream period_2", 32'(done_at[2] - done_at[1]), 32'd5);
        end
        repeat (8) @(negedge CLK);
        check("final idle", 32'(Busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
